mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store sequencer for a word-addressed data memory with sub-word RMW stores.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        mrd_q, mrd_d;
    logic        mwr_q, mwr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        trap, last;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld, merged;

`ifdef MISALIGN_TRAP_EN
    assign trap = size[1] ? |addr[1:0] : size[0] & addr[0];
`else
    assign trap = 1'b0;
`endif

    assign last = cnt_q == 4'(WAIT_CYCLES);
    assign b = ReadData[8*lane_q +: 8];
    assign h = ReadData[16*lane_q[1] +: 16];
    assign ld = size_q[1] ? ReadData : size_q[0] ? {{16{sext_q & h[15]}}, h} : {{24{sext_q & b[7]}}, b};

    always_comb begin
        merged = ReadData;
        if (size_q[0]) merged[16*lane_q[1] +: 16] = wdata_q;
        else merged[8*lane_q +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        mrd_d   = 1'b0;
        mwr_d   = 1'b0;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                we_d    = we;
                size_d  = size;
                sext_d  = sign_ext;
                lane_d  = addr[1:0];
                wdata_d = wdata[15:0];
                addr_d  = {addr[31:2], 2'b00};
                cnt_d   = '0;
                if (trap) begin
                    state_d = DONE;
                    mis_d   = 1'b1;
                end else if (!we || !size[1]) begin
                    state_d = RD;
                    mrd_d   = 1'b1;
                end else begin
                    state_d = WR;
                    mwr_d   = 1'b1;
                    wd_d    = wdata;
                end
            end
            RD: begin
                cnt_d = last ? 4'd0 : cnt_q + 4'd1;
                mrd_d = !last;
                if (last && we_q) begin
                    state_d = WR;
                    mwr_d   = 1'b1;
                    wd_d    = merged;
                end else if (last) begin
                    state_d = DONE;
                    rdata_d = ld;
                end
            end
            WR: begin
                cnt_d   = last ? 4'd0 : cnt_q + 4'd1;
                mwr_d   = !last;
                state_d = last ? DONE : WR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            lane_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    assign ready     = state_q == IDLE;
    assign done      = state_q == DONE;
    assign rdata     = rdata_q;
    assign misalign  = mis_q;
    assign Address   = addr_q;
    assign WriteData = wd_q;
    assign MemRead   = mrd_q;
    assign MemWrite  = mwr_q;
endmodule
